// File: rtl/irb_dma_engine.sv
// irb_dma_engine
//   DMA engine serving the main controller's load/store requests. Moves 32-bit
//   words between external memory and the on-chip buffers. Loads the 64-bit
//   layer descriptor (INF op) and pulses f_dma when each request finishes.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   s_dma, dma_op            start pulse and op code (0 INF,1 FMI,2 KEX,3 KPW,4 KDW,5 FMO)
//   dma_mem_info1/2          word offsets added to the op's region base
//   base_*                   region base addresses
//   cfg_*                    tile geometry, row strides, linear lengths
//   ext_*                    external memory request/response bus
//   buf_*                    on-chip buffer port (buf_sel = latched op)
//   inf_conv                 layer descriptor loaded by INF
//   f_dma, busy              done pulse, activity flag
module irb_dma_engine #(
  parameter int DW      = 32,
  parameter int AW      = 32,
  parameter int BAW     = 16,
  parameter int MAX_OUT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            s_dma,
  input  logic [2:0]      dma_op,
  input  logic [31:0]     dma_mem_info1,
  input  logic [31:0]     dma_mem_info2,
  input  logic [31:0]     base_inf,
  input  logic [31:0]     base_fmi,
  input  logic [31:0]     base_kex,
  input  logic [31:0]     base_kpw,
  input  logic [31:0]     base_kdw,
  input  logic [31:0]     base_fmo,
  input  logic [7:0]      cfg_tiw,
  input  logic [7:0]      cfg_tih,
  input  logic [7:0]      cfg_tow,
  input  logic [7:0]      cfg_toh,
  input  logic [15:0]     cfg_img_w,
  input  logic [15:0]     cfg_out_w,
  input  logic [15:0]     cfg_len_kex,
  input  logic [15:0]     cfg_len_kpw,
  input  logic [15:0]     cfg_len_kdw,
  output logic [AW-1:0]   ext_addr,
  output logic            ext_rd,
  output logic            ext_wr,
  input  logic            ext_ready,
  output logic [DW-1:0]   ext_wdata,
  input  logic [DW-1:0]   ext_rdata,
  input  logic            ext_rvalid,
  output logic [2:0]      buf_sel,
  output logic            buf_we,
  output logic            buf_re,
  output logic [BAW-1:0]  buf_addr,
  output logic [DW-1:0]   buf_wdata,
  input  logic [DW-1:0]   buf_rdata,
  output logic [63:0]     inf_conv,
  output logic            f_dma,
  output logic            busy
);

  localparam int CW = 17;
  localparam logic [2:0] OP_INF = 3'd0, OP_FMI = 3'd1, OP_KEX = 3'd2,
                         OP_KPW = 3'd3, OP_KDW = 3'd4, OP_FMO = 3'd5;
  localparam logic [3:0] OUT_LIMIT = 4'(MAX_OUT);

  typedef enum logic [2:0] {IDLE, RD, WR_FETCH, WR_PUSH, DONE} state_t;

  state_t          state, state_nx;
  logic [2:0]      op_q;
  logic [AW-1:0]   addr_q, row_base_q;
  logic [CW-1:0]   col_q, width_q, total_q, issued_q, recv_q, idx_q;
  logic [15:0]     stride_q;
  logic [3:0]      outst_q;
  logic            push_first_q;
  logic [DW-1:0]   wdata_q;

  logic            start, rd_acc, wr_acc, rv_ok, col_wrap;
  logic [31:0]     start_base;
  logic [AW-1:0]   start_addr;
  logic [CW-1:0]   start_total, start_width;
  logic [15:0]     start_stride;

  // Linear ops use width = total so the column never wraps mid-transfer.
  always_comb begin
    start_base   = '0;
    start_total  = '0;
    start_width  = '0;
    start_stride = '0;
    case (dma_op)
      OP_INF: begin
        start_base  = base_inf;
        start_total = CW'(2);
        start_width = CW'(2);
      end
      OP_FMI: begin
        start_base   = base_fmi;
        start_total  = {9'd0, cfg_tiw} * {9'd0, cfg_tih};
        start_width  = CW'(cfg_tiw);
        start_stride = cfg_img_w;
      end
      OP_KEX: begin
        start_base  = base_kex;
        start_total = CW'(cfg_len_kex);
        start_width = CW'(cfg_len_kex);
      end
      OP_KPW: begin
        start_base  = base_kpw;
        start_total = CW'(cfg_len_kpw);
        start_width = CW'(cfg_len_kpw);
      end
      OP_KDW: begin
        start_base  = base_kdw;
        start_total = CW'(cfg_len_kdw);
        start_width = CW'(cfg_len_kdw);
      end
      OP_FMO: begin
        start_base   = base_fmo;
        start_total  = {9'd0, cfg_tow} * {9'd0, cfg_toh};
        start_width  = CW'(cfg_tow);
        start_stride = cfg_out_w;
      end
      default: ;
    endcase
  end

  assign start_addr = AW'(start_base + dma_mem_info1 + dma_mem_info2);
  // The f_dma cycle is still treated as busy, so a start there is dropped.
  assign start      = s_dma && (state == IDLE) && !f_dma;
  assign ext_rd     = (state == RD) && (issued_q < total_q) && (outst_q < OUT_LIMIT);
  assign ext_wr     = (state == WR_PUSH);
  assign rd_acc     = ext_rd && ext_ready;
  assign wr_acc     = ext_wr && ext_ready;
  assign rv_ok      = (state == RD) && ext_rvalid && (outst_q != '0);
  assign col_wrap   = (col_q + CW'(1)) == width_q;

  assign ext_addr   = (ext_rd || ext_wr) ? addr_q : '0;
  // First push cycle forwards the buffer output directly; later stalled
  // cycles use the copy captured at the end of that first cycle.
  assign ext_wdata  = !ext_wr ? '0 : (push_first_q ? buf_rdata : wdata_q);
  assign buf_sel    = op_q;
  assign buf_we     = rv_ok && (op_q != OP_INF);
  assign buf_re     = (state == WR_FETCH);
  assign buf_addr   = buf_we ? recv_q[BAW-1:0] : (buf_re ? idx_q[BAW-1:0] : '0);
  assign buf_wdata  = buf_we ? ext_rdata : '0;
  assign busy       = (state != IDLE) || f_dma;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start) begin
        if (start_total == '0)     state_nx = DONE;
        else if (dma_op == OP_FMO) state_nx = WR_FETCH;
        else                       state_nx = RD;
      end
      RD:       if (rv_ok && (recv_q + CW'(1)) == total_q) state_nx = DONE;
      WR_FETCH: state_nx = WR_PUSH;
      WR_PUSH:  if (wr_acc) state_nx = ((idx_q + CW'(1)) == total_q) ? DONE : WR_FETCH;
      DONE:     state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q         <= '0;
      addr_q       <= '0;
      row_base_q   <= '0;
      col_q        <= '0;
      width_q      <= '0;
      total_q      <= '0;
      stride_q     <= '0;
      issued_q     <= '0;
      recv_q       <= '0;
      outst_q      <= '0;
      idx_q        <= '0;
      push_first_q <= 1'b0;
      wdata_q      <= '0;
      inf_conv     <= '0;
      f_dma        <= 1'b0;
    end else begin
      f_dma        <= (state == DONE);
      push_first_q <= (state == WR_FETCH);
      if (push_first_q) wdata_q <= buf_rdata;

      if (start) begin
        op_q       <= dma_op;
        addr_q     <= start_addr;
        row_base_q <= start_addr;
        col_q      <= '0;
        width_q    <= start_width;
        total_q    <= start_total;
        stride_q   <= start_stride;
        issued_q   <= '0;
        recv_q     <= '0;
        outst_q    <= '0;
        idx_q      <= '0;
      end else begin
        if (rd_acc || wr_acc) begin
          if (col_wrap) begin
            col_q      <= '0;
            row_base_q <= row_base_q + AW'(stride_q);
            addr_q     <= row_base_q + AW'(stride_q);
          end else begin
            col_q  <= col_q + CW'(1);
            addr_q <= addr_q + AW'(1);
          end
        end
        if (rd_acc) issued_q <= issued_q + CW'(1);
        if (wr_acc) idx_q    <= idx_q + CW'(1);
        if (rd_acc && !rv_ok)      outst_q <= outst_q + 4'd1;
        else if (!rd_acc && rv_ok) outst_q <= outst_q - 4'd1;
        if (rv_ok) begin
          recv_q <= recv_q + CW'(1);
          if (op_q == OP_INF) begin
            if (recv_q == '0) inf_conv[31:0]  <= ext_rdata;
            else              inf_conv[63:32] <= ext_rdata;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_irb_dma_engine.sv
module tb_irb_dma_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_dma = 1'b0;
  logic [2:0]  dma_op = '0;
  logic [31:0] dma_mem_info1 = '0, dma_mem_info2 = '0;
  logic [31:0] base_inf = '0, base_fmi = '0, base_kex = '0, base_kpw = '0, base_kdw = '0, base_fmo = '0;
  logic [7:0]  cfg_tiw = '0, cfg_tih = '0, cfg_tow = '0, cfg_toh = '0;
  logic [15:0] cfg_img_w = '0, cfg_out_w = '0, cfg_len_kex = '0, cfg_len_kpw = '0, cfg_len_kdw = '0;
  logic [31:0] ext_addr;
  logic        ext_rd, ext_wr;
  logic        ext_ready = 1'b0;
  logic [31:0] ext_wdata;
  logic [31:0] ext_rdata = '0;
  logic        ext_rvalid = 1'b0;
  logic [2:0]  buf_sel;
  logic        buf_we, buf_re;
  logic [15:0] buf_addr;
  logic [31:0] buf_wdata;
  logic [31:0] buf_rdata = '0;
  logic [63:0] inf_conv;
  logic        f_dma, busy;

  irb_dma_engine #(.DW(32), .AW(32), .BAW(16), .MAX_OUT(4)) dut (
    .clk(clk), .rst(rst), .s_dma(s_dma), .dma_op(dma_op),
    .dma_mem_info1(dma_mem_info1), .dma_mem_info2(dma_mem_info2),
    .base_inf(base_inf), .base_fmi(base_fmi), .base_kex(base_kex),
    .base_kpw(base_kpw), .base_kdw(base_kdw), .base_fmo(base_fmo),
    .cfg_tiw(cfg_tiw), .cfg_tih(cfg_tih), .cfg_tow(cfg_tow), .cfg_toh(cfg_toh),
    .cfg_img_w(cfg_img_w), .cfg_out_w(cfg_out_w),
    .cfg_len_kex(cfg_len_kex), .cfg_len_kpw(cfg_len_kpw), .cfg_len_kdw(cfg_len_kdw),
    .ext_addr(ext_addr), .ext_rd(ext_rd), .ext_wr(ext_wr), .ext_ready(ext_ready),
    .ext_wdata(ext_wdata), .ext_rdata(ext_rdata), .ext_rvalid(ext_rvalid),
    .buf_sel(buf_sel), .buf_we(buf_we), .buf_re(buf_re), .buf_addr(buf_addr),
    .buf_wdata(buf_wdata), .buf_rdata(buf_rdata),
    .inf_conv(inf_conv), .f_dma(f_dma), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- external memory / buffer responder ----------------
  typedef struct packed {logic [31:0] a; logic [31:0] d; logic [2:0] s;} xfer_t;

  logic [31:0] mem_ovr [logic [31:0]];
  logic [31:0] fmo_buf [0:255];
  xfer_t       bw_log[$];
  xfer_t       wr_log[$];
  logic [31:0] rd_log[$];
  int          rq_due[$];
  logic [31:0] rq_data[$];

  int  cyc = 0, fcnt = 0, req_cycles = 0, viol = 0, max_os = 0, rv_cnt = 0, last_rv = -100;
  int  wait_cnt = 0, stall = 0;
  int  g_stall_max = 0, g_lat_min = 1, g_lat_max = 1, g_rv_pct = 100;
  bit  g_stall_fixed = 1'b1, g_spur = 1'b0;
  bit  rv_real = 1'b0, prev_pend = 1'b0, prev_rd = 1'b0, prev_wr = 1'b0, re_hit = 1'b0;
  logic [31:0] prev_addr = '0, prev_data = '0;
  logic [15:0] re_addr = '0;

  function automatic logic [31:0] memval(input logic [31:0] a);
    if (mem_ovr.exists(a)) return mem_ovr[a];
    return (a * 32'h9E3779B1) ^ 32'h0F1E2D3C;
  endfunction

  function automatic int new_stall();
    return g_stall_fixed ? g_stall_max : int'($urandom_range(g_stall_max, 0));
  endfunction

  always @(posedge clk) begin
    xfer_t e;
    if (rst) begin
      rq_due.delete(); rq_data.delete();
      prev_pend = 1'b0; wait_cnt = 0; stall = new_stall(); re_hit = 1'b0;
    end else begin
      if (ext_rd && ext_wr) viol++;
      if (prev_pend && (ext_rd !== prev_rd || ext_wr !== prev_wr || ext_addr !== prev_addr ||
                        (prev_wr && ext_wdata !== prev_data))) viol++;
      if (ext_rd || ext_wr) req_cycles++;
      if (ext_rvalid && rv_real) begin rv_cnt++; last_rv = cyc; end
      if (ext_rd && ext_ready) begin
        rd_log.push_back(ext_addr);
        rq_due.push_back(cyc + int'($urandom_range(g_lat_max, g_lat_min)));
        rq_data.push_back(memval(ext_addr));
        if (rq_due.size() > max_os) max_os = rq_due.size();
      end
      if (ext_wr && ext_ready) begin
        e.a = ext_addr; e.d = ext_wdata; e.s = 3'd0; wr_log.push_back(e);
      end
      if (buf_we) begin
        e.a = {16'd0, buf_addr}; e.d = buf_wdata; e.s = buf_sel; bw_log.push_back(e);
      end
      if (f_dma) fcnt++;
      prev_pend = (ext_rd || ext_wr) && !ext_ready;
      prev_rd = ext_rd; prev_wr = ext_wr; prev_addr = ext_addr; prev_data = ext_wdata;
      if (ext_rd || ext_wr) begin
        if (ext_ready) begin wait_cnt = 0; stall = new_stall(); end
        else wait_cnt++;
      end
      re_hit = buf_re; re_addr = buf_addr;
    end
    cyc++;
    #1;
    buf_rdata = re_hit ? fmo_buf[re_addr[7:0]] : $urandom;
    ext_ready = (wait_cnt >= stall);
    if (rq_due.size() > 0 && rq_due[0] <= cyc && int'($urandom_range(99, 0)) < g_rv_pct) begin
      ext_rvalid = 1'b1; ext_rdata = rq_data[0]; rv_real = 1'b1;
      void'(rq_due.pop_front()); void'(rq_data.pop_front());
    end else if (rq_due.size() == 0 && g_spur && $urandom_range(3, 0) == 0) begin
      ext_rvalid = 1'b1; ext_rdata = $urandom; rv_real = 1'b0;
    end else begin
      ext_rvalid = 1'b0; ext_rdata = $urandom; rv_real = 1'b0;
    end
  end

  // ---------------- reference model and op runner ----------------
  logic [63:0] exp_inf = '0;

  task automatic check_idle_outputs();
    check("rst_ext_rd",    ext_rd,    0);
    check("rst_ext_wr",    ext_wr,    0);
    check("rst_ext_addr",  ext_addr,  0);
    check("rst_ext_wdata", ext_wdata, 0);
    check("rst_buf_we",    buf_we,    0);
    check("rst_buf_re",    buf_re,    0);
    check("rst_buf_addr",  buf_addr,  0);
    check("rst_buf_wdata", buf_wdata, 0);
    check("rst_buf_sel",   buf_sel,   0);
    check("rst_inf_conv",  inf_conv,  0);
    check("rst_f_dma",     f_dma,     0);
    check("rst_busy",      busy,      0);
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] i1, input logic [31:0] i2);
    logic [31:0] base, start;
    logic [31:0] exp_a[$];
    int w, h, stride, total, t0, tf, fc0, rq0, n;
    @(negedge clk);
    base = 0; w = 0; h = 0; stride = 0;
    case (op)
      3'd0: begin base = base_inf; w = 2; h = 1; end
      3'd1: begin base = base_fmi; w = cfg_tiw; h = cfg_tih; stride = cfg_img_w; end
      3'd2: begin base = base_kex; w = cfg_len_kex; h = 1; end
      3'd3: begin base = base_kpw; w = cfg_len_kpw; h = 1; end
      3'd4: begin base = base_kdw; w = cfg_len_kdw; h = 1; end
      3'd5: begin base = base_fmo; w = cfg_tow; h = cfg_toh; stride = cfg_out_w; end
      default: ;
    endcase
    start = base + i1 + i2;
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++)
        exp_a.push_back(start + 32'(r * stride) + 32'(c));
    total = exp_a.size();
    if (op == 3'd5) for (int i = 0; i < 256; i++) fmo_buf[i] = $urandom;
    rd_log.delete(); bw_log.delete(); wr_log.delete();
    max_os = 0; viol = 0; rv_cnt = 0; last_rv = -100;
    fc0 = fcnt; rq0 = req_cycles;
    dma_op = op; dma_mem_info1 = i1; dma_mem_info2 = i2; s_dma = 1'b1; t0 = cyc;
    @(negedge clk);
    s_dma = 1'b0;
    check("busy_start", busy, 1);
    tf = -1;
    for (int k = 0; k < 4000; k++) begin
      if (f_dma === 1'b1) begin tf = cyc; break; end
      @(negedge clk);
    end
    if (tf < 0) begin check("f_dma_timeout", 0, 1); return; end
    check("busy_at_fdma", busy, 1);
    @(negedge clk);
    check("f_dma_one_cycle", f_dma, 0);
    check("busy_after", busy, 0);
    @(negedge clk);
    check("f_dma_count", fcnt - fc0, 1);
    if (total == 0) begin
      check("zero_done_latency", tf - t0, 2);
      check("zero_no_bus", req_cycles - rq0, 0);
    end else if (op != 3'd5) begin
      check("rd_done_latency", tf - last_rv, 2);
    end
    if (op == 3'd0) exp_inf = {memval(exp_a[1]), memval(exp_a[0])};
    check("inf_conv", inf_conv, exp_inf);
    check("bus_rules", viol, 0);
    check("outstanding_le_max", max_os <= 4, 1);
    if (op <= 3'd4) begin
      check("rd_count", rd_log.size(), total);
      check("wr_none", wr_log.size(), 0);
      n = (rd_log.size() < total) ? rd_log.size() : total;
      for (int i = 0; i < n; i++) check("rd_addr", rd_log[i], exp_a[i]);
      check("bw_count", bw_log.size(), (op == 3'd0) ? 0 : total);
      if (op != 3'd0) begin
        n = (bw_log.size() < total) ? bw_log.size() : total;
        for (int i = 0; i < n; i++) begin
          check("bw_addr", bw_log[i].a, 32'(i));
          check("bw_data", bw_log[i].d, memval(exp_a[i]));
          check("bw_sel",  bw_log[i].s, op);
        end
      end
    end else if (op == 3'd5) begin
      check("rd_none", rd_log.size(), 0);
      check("wr_count", wr_log.size(), total);
      n = (wr_log.size() < total) ? wr_log.size() : total;
      for (int i = 0; i < n; i++) begin
        check("wr_addr", wr_log[i].a, exp_a[i]);
        check("wr_data", wr_log[i].d, fmo_buf[i]);
      end
    end else begin
      check("illegal_no_rd", rd_log.size(), 0);
      check("illegal_no_wr", wr_log.size(), 0);
    end
  endtask

  initial begin
    int fc0, ok;
    repeat (3) @(negedge clk);
    check_idle_outputs();
    rst = 1'b0;

    // INF descriptor load, read latency 3
    base_inf = 32'h100;
    mem_ovr[32'h100] = 32'hAAAA0001;
    mem_ovr[32'h101] = 32'h0000BBBB;
    g_lat_min = 3; g_lat_max = 3;
    run_op(3'd0, 32'd0, 32'd0);
    check("inf_conv_plan", inf_conv, 64'h0000BBBB_AAAA0001);

    // FMI tile 3x2, stride 10, offsets 4+20
    cfg_tiw = 8'd3; cfg_tih = 8'd2; cfg_img_w = 16'd10; base_fmi = 32'd0;
    g_lat_min = 1; g_lat_max = 4;
    run_op(3'd1, 32'd4, 32'd20);

    // KEX, long latency exercises the outstanding cap
    cfg_len_kex = 16'd8; base_kex = 32'h2000;
    g_lat_min = 10; g_lat_max = 10;
    run_op(3'd2, 32'd0, 32'd3);
    check("kex_os_peak", max_os, 4);

    // FMO with 3 stalled cycles per request
    cfg_tow = 8'd2; cfg_toh = 8'd2; cfg_out_w = 16'd5; base_fmo = 32'h3000;
    g_stall_max = 3; g_stall_fixed = 1'b1; g_lat_min = 1; g_lat_max = 2;
    run_op(3'd5, 32'd0, 32'd0);
    g_stall_max = 0;

    // zero length and illegal op
    cfg_len_kpw = 16'd0;
    run_op(3'd3, 32'd7, 32'd0);
    run_op(3'd7, 32'd0, 32'd0);

    // reset in the middle of a KDW read
    cfg_len_kdw = 16'd10; base_kdw = 32'h4000; g_lat_min = 2; g_lat_max = 5;
    @(negedge clk);
    rv_cnt = 0; dma_op = 3'd4; s_dma = 1'b1;
    @(negedge clk);
    s_dma = 1'b0;
    ok = 0;
    for (int k = 0; k < 500; k++) begin
      if (rv_cnt >= 3) begin ok = 1; break; end
      @(negedge clk);
    end
    check("kdw_reads_before_reset", ok, 1);
    rst = 1'b1;
    #1;
    check_idle_outputs();
    fc0 = fcnt;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("no_f_dma_after_abort", fcnt - fc0, 0);
    exp_inf = '0;
    cfg_len_kex = 16'd5;
    run_op(3'd2, 32'd1, 32'd1);

    // randomized ops
    for (int t = 0; t < 40; t++) begin
      base_inf = $urandom; base_fmi = $urandom; base_kex = $urandom;
      base_kpw = $urandom; base_kdw = $urandom; base_fmo = $urandom;
      cfg_tiw = 8'($urandom_range(4, 0)); cfg_tih = 8'($urandom_range(3, 0));
      cfg_tow = 8'($urandom_range(3, 0)); cfg_toh = 8'($urandom_range(3, 0));
      cfg_img_w = 16'($urandom_range(20, 0)); cfg_out_w = 16'($urandom_range(20, 0));
      cfg_len_kex = 16'($urandom_range(9, 0)); cfg_len_kpw = 16'($urandom_range(9, 0));
      cfg_len_kdw = 16'($urandom_range(9, 0));
      g_stall_max = int'($urandom_range(3, 0)); g_stall_fixed = 1'b0;
      g_lat_min = int'($urandom_range(3, 1)); g_lat_max = g_lat_min + int'($urandom_range(6, 0));
      g_rv_pct = int'($urandom_range(100, 40)); g_spur = 1'($urandom_range(1, 0));
      run_op(3'($urandom_range(7, 0)), $urandom, 32'($urandom_range(50, 0)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/irb_dma_engine.md
Name: irb_dma_engine

Overview:
- DMA engine directly downstream of the main controller, serving its load/store requests: INF, FMI tile, KEX/KPW/KDW weights, and FMO tile write-back.
- Moves 32-bit words between external memory and the on-chip buffers (buffer selected per op).
- Loads the 64-bit layer descriptor inf_conv.
- Pulses f_dma when each request completes.

Parameters:
- DW, 32, data word width (fixed at 32).
- AW, 32, external address width.
- BAW, 16, on-chip buffer address width.
- MAX_OUT, 4, max outstanding external reads (2..15).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- s_dma  in  1  start pulse; op/info sampled same cycle
- dma_op  in  3  0=INF 1=FMI 2=KEX 3=KPW 4=KDW 5=FMO (6,7 illegal)
- dma_mem_info1, dma_mem_info2  in  32  address offsets (words), summed with base
- base_inf, base_fmi, base_kex, base_kpw, base_kdw, base_fmo  in  32  region base addresses
- cfg_tiw, cfg_tih, cfg_tow, cfg_toh  in  8  input/output tile width/height (words)
- cfg_img_w, cfg_out_w  in  16  external row stride, input/output map
- cfg_len_kex, cfg_len_kpw, cfg_len_kdw  in  16  linear transfer lengths (words)
- ext_addr  out  AW  word address
- ext_rd, ext_wr  out  1  request; held until ext_ready
- ext_ready  in  1  request accepted this cycle
- ext_wdata  out  DW  write data
- ext_rdata  in  DW  read data
- ext_rvalid  in  1  read data valid, in order, ≥1 cycle after acceptance
- buf_sel  out  3  target buffer = latched op
- buf_we, buf_re  out  1  buffer write/read strobe
- buf_addr  out  BAW  buffer address
- buf_wdata  out  DW  buffer write data
- buf_rdata  in  DW  buffer read data, valid cycle after buf_re
- inf_conv  out  64  layer descriptor
- f_dma  out  1  one-cycle done pulse
- busy  out  1  high from cycle after s_dma until f_dma cycle, inclusive

Behaviour:
- Reset (async, immediate): all outputs 0; state IDLE; counters 0; inf_conv 0. A reset mid-transfer aborts it, no f_dma is issued, and ext_rd/ext_wr drop immediately.
- States: IDLE, RD, WR_FETCH, WR_PUSH, DONE.
- IDLE: on s_dma, latch op, start address, geometry.
  - Start address = base(op) + mem_info1 + mem_info2 (mod 2^32).
  - Op 0–4 → RD. Op 5 → WR_FETCH. Op 6/7 → DONE with no transfers.
  - s_dma outside IDLE is ignored.
- Geometry:
  - INF: 2 words, linear.
  - KEX/KPW/KDW: cfg_len_* words, linear.
  - FMI: cfg_tih rows × cfg_tiw words. Row r starts at start + r·cfg_img_w.
  - FMO: cfg_toh × cfg_tow, stride cfg_out_w.
  - Zero length/width/height → DONE directly, no bus activity.
- RD:
  - Issue ext_rd while issued < total and outstanding < MAX_OUT.
  - Address advances only on ext_ready.
  - Column counter wraps at width; the row base then adds the stride.
  - Outstanding count: +1 on acceptance, −1 on rvalid. Simultaneous accept and rvalid leaves it unchanged.
  - Each rvalid writes ext_rdata to buf_addr = received index, sequential from 0 packed, with buf_we the same cycle.
  - INF op: no buffer write. Word 0 → inf_conv[31:0], word 1 → inf_conv[63:32]. inf_conv holds its value until the next INF op or reset.
  - Go to DONE the cycle after the last rvalid.
- WR:
  - WR_FETCH asserts buf_re at the index (from 0), then WR_PUSH.
  - WR_PUSH holds ext_wr with ext_wdata = buf_rdata registered, at the tile-strided address, until ext_ready.
  - Then advance the index and return to WR_FETCH, or go to DONE after the last word.
  - Throughput is 1 word per 2 cycles minimum.
- DONE: f_dma = 1 for exactly one cycle, then IDLE. Earliest next s_dma is the cycle after f_dma.
- Bus rules:
  - ext_rd and ext_wr are never both high.
  - ext_addr/ext_wdata are stable while a request is pending.
  - ext_rvalid with no outstanding read is ignored.
- Widths:
  - Internal word counters are 17 bits (cfg_tiw·cfg_tih ≤ 65025; linear lengths ≤ 65535).
  - buf_addr is the index truncated to BAW.

Test Plan:
- INF: base_inf=0x100, s_dma op0, memory[0x100]=0xAAAA0001, [0x101]=0x0000BBBB, rvalid latency 3 → inf_conv=0x0000BBBB_AAAA0001, no buf_we, f_dma single pulse, busy low after.
- FMI tile: tiw=3, tih=2, img_w=10, base_fmi=0, mem_info1=4, mem_info2=20 → reads at 24,25,26,34,35,36; buf_addr 0..5, buf_sel=1; f_dma after 6th rvalid.
- Outstanding limit: KEX len=8, MAX_OUT=4, rvalid delayed 10 cycles → never more than 4 accepted-unreturned; all 8 words land at buf_addr 0..7 in order.
- Backpressure on FMO: tow=2, toh=2, out_w=5, ext_ready low 3 cycles per request → writes to base_fmo+{0,1,5,6} with buffer words 0..3; address/data stable while stalled.
- Zero/illegal: cfg_len_kpw=0 op3, then op7 → each gives f_dma 2 cycles after s_dma, no ext_rd/ext_wr.
- Reset mid-op: assert rst during KDW after 3 of 10 reads → all outputs 0 immediately, no f_dma; a fresh op2 after reset completes normally.
